// File: rtl/matrix_result_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_result_reader_pkg
// Purpose  : Shared types and helpers for the matrix result reader: drain FSM
//            state encoding, sticky error bit indices, depth/index helpers.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_result_reader_pkg;

  // Drain state machine encoding
  typedef enum logic [1:0] {
    CAPTURE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_HOLD  = 2'd2,
    FINISH   = 2'd3
  } state_t;

  // Bit positions inside the sticky error vector
  localparam int c_ERR_RANGE   = 0;
  localparam int c_ERR_OVERLAP = 1;
  localparam int c_ERR_COUNT   = 2;
  localparam int c_ERR_W       = 3;

  // Number of result entries held in the local RAM
  function automatic int calc_depth(input int rows, input int cols);
    return rows * cols;
  endfunction

  // Index width for a counter spanning n values (never below one bit)
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_result_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_result_reader_if
// Purpose  : Bundles the multiplier z write port, busy flag, the result
//            valid/ready stream and the sticky error flags.
//            MATRIX_RESULT_ROW_END_EN adds the out_row_end marker.
// Revision : 1.0 - initial release
// ============================================================================
interface matrix_result_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] z_addr;
  logic [DATA_WIDTH-1:0] z_data;
  logic                  z_wen;
  logic                  mm_busy;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  drain_done;
  logic                  err_range;
  logic                  err_overlap;
  logic                  err_count;
`ifdef MATRIX_RESULT_ROW_END_EN
  logic                  out_row_end;
`endif

  // Reader side: consumes writes, produces the result stream
  modport master (
`ifdef MATRIX_RESULT_ROW_END_EN
    output out_row_end,
`endif
    input  z_addr, z_data, z_wen, mm_busy, out_ready,
    output out_data, out_valid, out_last, drain_done,
    output err_range, err_overlap, err_count
  );

  // Multiplier/host side
  modport slave (
`ifdef MATRIX_RESULT_ROW_END_EN
    input  out_row_end,
`endif
    output z_addr, z_data, z_wen, mm_busy, out_ready,
    input  out_data, out_valid, out_last, drain_done,
    input  err_range, err_overlap, err_count
  );

endinterface
`default_nettype wire

// File: rtl/matrix_result_reader_result_ram.sv
`default_nettype none
// ============================================================================
// Module   : result_ram
// Purpose  : Simple dual-port result store, synchronous write, registered
//            one-cycle read. Contents are not cleared by reset; only the
//            read register is.
// Revision : 1.0 - initial release
// ============================================================================
module result_ram #(
  parameter int DEPTH      = 25,
  parameter int DATA_WIDTH = 32,
  parameter int PTR_W      = 5
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  we,
  input  wire logic [PTR_W-1:0]      waddr,
  input  wire logic [DATA_WIDTH-1:0] wdata,
  input  wire logic                  re,
  input  wire logic [PTR_W-1:0]      raddr,
  output      logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Read register; only updated on an explicit read so it holds during stalls
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/matrix_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : matrix_result_reader
// Purpose  : Captures multiplier z writes into a local RAM and, on the falling
//            edge of mm_busy, streams the X_ROWS x Y_COLS result row-major
//            over valid/ready. Tracks sticky range/overlap/count errors.
//            Option macro: MATRIX_RESULT_ROW_END_EN (adds out_row_end).
// Revision : 1.0 - initial release
// ============================================================================
module matrix_result_reader
  import matrix_result_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int X_ROWS     = 5,
  parameter int Y_COLS     = 5
) (
  input wire logic              clk,
  input wire logic              rst,
  matrix_result_reader_if.master bus
);

  localparam int                    c_DEPTH   = calc_depth(X_ROWS, Y_COLS);
  localparam int                    c_PTR_W   = idx_width(c_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_DEPTH_A = ADDR_WIDTH'(c_DEPTH);
  localparam logic [c_PTR_W-1:0]    c_LAST    = c_PTR_W'(c_DEPTH - 1);

  state_t                r_state, w_state_next;
  logic                  r_busy_q;
  logic [ADDR_WIDTH-1:0] r_wr_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_next;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_ERR_W-1:0]    r_err;
  logic                  w_fall, w_in_range, w_wr_ok, w_is_last, w_handshake;
  logic                  w_out_valid, w_out_last, w_drain_done, w_rd_en;

  assign w_fall      = r_busy_q && !bus.mm_busy;
  assign w_in_range  = bus.z_addr < c_DEPTH_A;
  assign w_wr_ok     = (r_state == CAPTURE) && bus.z_wen && w_in_range;
  assign w_is_last   = r_rd_ptr == c_LAST;
  assign w_handshake = (r_state == RD_HOLD) && bus.out_ready;
  // A write landing on the falling-edge cycle counts before the DEPTH compare
  assign w_cnt_next  = (w_wr_ok && r_wr_cnt != '1) ? r_wr_cnt + ADDR_WIDTH'(1) : r_wr_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= CAPTURE;
    else     r_state <= w_state_next;
  end

  // Next-state and stream control decode
  always_comb begin
    w_state_next = r_state;
    w_out_valid  = 1'b0;
    w_out_last   = 1'b0;
    w_drain_done = 1'b0;
    w_rd_en      = 1'b0;
    case (r_state)
      CAPTURE:  if (w_fall) w_state_next = RD_ISSUE;
      RD_ISSUE: begin
        w_rd_en      = 1'b1;
        w_state_next = RD_HOLD;
      end
      RD_HOLD: begin
        w_out_valid = 1'b1;
        w_out_last  = w_is_last;
        if (bus.out_ready) w_state_next = w_is_last ? FINISH : RD_ISSUE;
      end
      FINISH: begin
        w_drain_done = 1'b1;
        w_state_next = CAPTURE;
      end
      default: w_state_next = CAPTURE;
    endcase
  end

  // Busy edge detect, write counter, read pointer and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_q <= 1'b0;
      r_wr_cnt <= '0;
      r_rd_ptr <= '0;
      r_err    <= '0;
    end else begin
      r_busy_q <= bus.mm_busy;
      if (r_state == CAPTURE) begin
        r_wr_cnt <= w_cnt_next;
        if (bus.z_wen && !w_in_range) r_err[c_ERR_RANGE] <= 1'b1;
        if (w_fall) begin
          r_rd_ptr <= '0;
          r_wr_cnt <= '0;
          if (w_cnt_next != c_DEPTH_A) r_err[c_ERR_COUNT] <= 1'b1;
        end
      end else if (bus.z_wen) begin
        r_err[c_ERR_OVERLAP] <= 1'b1;
      end
      if (w_handshake && !w_is_last) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
    end
  end

  result_ram #(
    .DEPTH      (c_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_W      (c_PTR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_wr_ok),
    .waddr (bus.z_addr[c_PTR_W-1:0]),
    .wdata (bus.z_data),
    .re    (w_rd_en),
    .raddr (r_rd_ptr),
    .rdata (bus.out_data)
  );

  assign bus.out_valid   = w_out_valid;
  assign bus.out_last    = w_out_last;
  assign bus.drain_done  = w_drain_done;
  assign bus.err_range   = r_err[c_ERR_RANGE];
  assign bus.err_overlap = r_err[c_ERR_OVERLAP];
  assign bus.err_count   = r_err[c_ERR_COUNT];

`ifdef MATRIX_RESULT_ROW_END_EN
  localparam int                 c_COL_W = idx_width(Y_COLS);
  localparam logic [c_COL_W-1:0] c_COL_E = c_COL_W'(Y_COLS - 1);
  logic [c_COL_W-1:0] r_col;

  // Column index of the element currently offered, wraps at each row end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
    end else if (r_state == CAPTURE && w_fall) begin
      r_col <= '0;
    end else if (w_handshake) begin
      r_col <= (r_col == c_COL_E) ? '0 : r_col + c_COL_W'(1);
    end
  end

  assign bus.out_row_end = w_out_valid && (r_col == c_COL_E);
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_result_reader
// Purpose  : Randomized self-checking bench for matrix_result_reader against
//            an array/scoreboard model of the result store and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_result_reader;

  localparam int c_DEPTH = 25;
  localparam int c_COLS  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_result_reader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  matrix_result_reader #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .X_ROWS     (5),
    .Y_COLS     (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  logic [31:0] m_ram [c_DEPTH];
  int          m_cnt;
  bit          m_err_range, m_err_overlap, m_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model a single z write seen while capturing
  task automatic model_write(input int addr, input logic [31:0] data);
    if (addr < c_DEPTH) begin
      m_ram[addr] = data;
      m_cnt++;
    end else begin
      m_err_range = 1'b1;
    end
  endtask

  task automatic check_errors(input string tag);
    check({tag, "_err_range"},   32'(bus.err_range),   32'(m_err_range));
    check({tag, "_err_overlap"}, 32'(bus.err_overlap), 32'(m_err_overlap));
    check({tag, "_err_count"},   32'(bus.err_count),   32'(m_err_count));
  endtask

  // kind 0: addr i, data i*3; kind 1: addr i, random data; kind 2: random addr/data
  task automatic capture(input int n, input int kind);
    int          a;
    logic [31:0] d;
    bus.mm_busy = 1'b1;
    bus.z_wen   = 1'b0;
    step();
    for (int i = 0; i < n; i++) begin
      a = (kind == 2) ? int'($urandom_range(0, 27)) : i;
      d = (kind == 0) ? 32'(i * 3) : $urandom;
      bus.z_wen  = 1'b1;
      bus.z_addr = 32'(a);
      bus.z_data = d;
      model_write(a, d);
      step();
      bus.z_wen = 1'b0;
      if ($urandom_range(0, 3) == 0) step();
    end
  endtask

  // mode 0: always ready; 1: ready 1,0,0,1 pattern; 2: random ready
  task automatic drain(input int mode, input bit overlap, input bit fall_wr,
                       input int abort_at);
    int          idx = 0;
    int          cyc = 0;
    int          pat = 0;
    bit          fin = 0;
    bit          stalled = 0;
    bit          rdy;
    logic [31:0] held = '0;
    logic [31:0] d;
    bus.mm_busy = 1'b0;
    if (fall_wr) begin
      d = $urandom;
      bus.z_wen  = 1'b1;
      bus.z_addr = 32'(c_DEPTH - 1);
      bus.z_data = d;
      model_write(c_DEPTH - 1, d);
    end
    if (m_cnt != c_DEPTH) m_err_count = 1'b1;
    m_cnt = 0;
    step();
    bus.z_wen = 1'b0;
    while (!fin && cyc < 300) begin
      if (idx == c_DEPTH) begin
        check("done_after_last", 32'(bus.drain_done), 32'd1);
        check("valid_in_finish", 32'(bus.out_valid), 32'd0);
        fin = 1;
      end else if (bus.out_valid) begin
        if (idx == abort_at) begin
          rst = 1'b1;
          bus.out_ready = 1'b0;
          step();
          check("abort_valid", 32'(bus.out_valid), 32'd0);
          check("abort_done",  32'(bus.drain_done), 32'd0);
          m_err_range = 0; m_err_overlap = 0; m_err_count = 0; m_cnt = 0;
          check_errors("abort");
          rst = 1'b0;
          step();
          check("abort_idle_valid", 32'(bus.out_valid), 32'd0);
          return;
        end
        check("data", bus.out_data, m_ram[idx]);
        check("last", 32'(bus.out_last), 32'(idx == c_DEPTH - 1));
`ifdef MATRIX_RESULT_ROW_END_EN
        check("row_end", 32'(bus.out_row_end), 32'((idx % c_COLS) == c_COLS - 1));
`endif
        if (stalled) check("stall_hold", bus.out_data, held);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (pat % 4 == 0) || (pat % 4 == 3);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        pat++;
        bus.out_ready = rdy;
        if (overlap && idx == 5) begin
          bus.z_wen  = 1'b1;
          bus.z_addr = 32'(idx);
          bus.z_data = ~m_ram[idx];
          m_err_overlap = 1'b1;
        end
        if (rdy) begin
          idx++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = bus.out_data;
        end
      end else begin
        check("no_early_done", 32'(bus.drain_done), 32'd0);
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      if (!fin) begin
        step();
        bus.z_wen = 1'b0;
        cyc++;
      end
    end
    if (!fin) check("drain_timeout", 32'd0, 32'd1);
    bus.out_ready = 1'b0;
    step();
    check("done_one_cycle", 32'(bus.drain_done), 32'd0);
    check("idle_valid",     32'(bus.out_valid),  32'd0);
  endtask

  initial begin
    bus.z_addr    = '0;
    bus.z_data    = '0;
    bus.z_wen     = 1'b0;
    bus.mm_busy   = 1'b0;
    bus.out_ready = 1'b0;
    m_cnt = 0; m_err_range = 0; m_err_overlap = 0; m_err_count = 0;
    repeat (3) step();
    check("rst_valid", 32'(bus.out_valid),  32'd0);
    check("rst_last",  32'(bus.out_last),   32'd0);
    check("rst_done",  32'(bus.drain_done), 32'd0);
    check("rst_data",  bus.out_data,        32'd0);
    check_errors("rst");
    rst = 1'b0;
    step();

    // Sequential fill with addr*3, always-ready drain
    capture(c_DEPTH, 0);
    drain(0, 0, 0, -1);
    check_errors("basic");

    // Stalling ready pattern
    capture(c_DEPTH, 1);
    drain(1, 0, 0, -1);
    check_errors("stall");

    // Out-of-range write alongside a full fill
    capture(c_DEPTH, 1);
    bus.z_wen = 1'b1; bus.z_addr = 32'd25; bus.z_data = 32'hDEAD;
    model_write(25, 32'hDEAD);
    step();
    bus.z_wen = 1'b0;
    drain(2, 0, 0, -1);
    check_errors("range");

    // Short fill: one write missing
    capture(c_DEPTH - 1, 1);
    drain(0, 0, 0, -1);
    check_errors("count");

    // Overlapping write during drain, last write on the falling-edge cycle
    capture(c_DEPTH - 1, 1);
    drain(2, 1, 1, -1);
    check_errors("overlap");

    // Reset mid-drain, then a fresh busy edge drains from address 0
    capture(c_DEPTH, 1);
    drain(0, 0, 0, 10);
    capture(0, 1);
    drain(1, 0, 0, -1);
    check_errors("post_abort");

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      capture(int'($urandom_range(20, 28)), 2);
      drain(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), -1);
      check_errors("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
